muldiv_seq: RTL and testbench
=============================

Name: muldiv_seq

Overview:
- Parametrised multi-cycle multiply/divide unit for the EX stage, with HI/LO result registers.
- EX-stage control issues it a 2-bit MULOp and a start pulse; mfhi/mflo read `hi`/`lo` directly.
- Generalises the old single-cycle multiplier: configurable width and per-class latency, a busy handshake for hazard stalling, and defined divide-by-zero and overflow results.

Parameters:
- WIDTH, 32, operand and HI/LO width.
- MUL_CYCLES, 5, cycles busy for mult/multu (>=1).
- DIV_CYCLES, 10, cycles busy for div/divu (>=1).

Ports:
- clk  input  1  clock, rising edge.
- rst_n  input  1  asynchronous reset, active-low.
- start  input  1  launch operation (one-cycle pulse).
- op  input  2  00 mult, 01 multu, 10 div, 11 divu.
- a  input  WIDTH  RS operand (multiplicand / dividend).
- b  input  WIDTH  RT operand (multiplier / divisor).
- mthi  input  1  write `wdata` to HI.
- mtlo  input  1  write `wdata` to LO.
- wdata  input  WIDTH  MTHI/MTLO data.
- busy  output  1  operation in flight; hazard unit stalls mfhi/mflo/mthi/mtlo/mult/div on this.
- hi  output  WIDTH  HI register.
- lo  output  WIDTH  LO register.

Behaviour:
- Reset: asserting rst_n low clears busy, hi and lo to 0 immediately, regardless of clk. An in-flight operation is discarded.
- States: IDLE, RUN. The counter is ceil(log2(max(MUL_CYCLES, DIV_CYCLES)+1)) bits wide.
- IDLE, start=1 at edge k:
  - latch a, b and op;
  - load counter with N, where N = MUL_CYCLES for op[1]=0 and DIV_CYCLES for op[1]=1;
  - go to RUN, busy=1 from edge k.
- RUN: counter decrements each edge. At edge k+N, commit the result to HI/LO, set busy=0 and go to IDLE.
- Busy timing: busy is high for exactly N cycles. A new start is accepted on the same edge that busy falls only if the start is sampled while in IDLE, i.e. never at edge k+N. The earliest next accepted start is edge k+N+1.
- start while busy: ignored; the latched operands are unaffected.
- mthi/mtlo:
  - take effect in IDLE only, at the edge they are sampled;
  - ignored while busy;
  - if start and mthi/mtlo are high in the same IDLE cycle, start wins and the write is dropped;
  - mthi and mtlo together write both HI and LO.
- mult: {HI, LO} = signed a * signed b, full 2*WIDTH product.
- multu: {HI, LO} = unsigned a * unsigned b.
- div:
  - LO = quotient truncated toward zero; HI = remainder with the sign of the dividend.
  - Overflow: a = 100..0 with b = all-ones gives LO = 100..0, HI = 0.
- divu: LO = a / b, HI = a % b (unsigned).
- Divide by zero (div or divu): LO = all-ones, HI = a. No exception is raised.
- Implementation choice: iterative or behavioural arithmetic is allowed, provided the latency is exact and HI/LO hold their old values until the commit edge.
- Read-during-run: hi/lo show the old values throughout RUN.

Optional Feature:
- Macro: MULDIV_FLUSH_EN.
- Defined: adds port `flush  input  1`, driven by the exception/interrupt logic.
  - flush=1 during RUN: abort at that edge, busy=0, HI/LO unchanged, state to IDLE.
  - flush=1 in IDLE together with start: the start is dropped.
  - flush at the commit edge (k+N): the abort wins, so no commit happens.
- Undefined: no flush port. An operation always runs to completion unless reset.

Test Plan:
- Signed multiply: reset, then mult a=0xFFFFFFFD (-3), b=5. busy is high for 5 cycles; then HI=0xFFFFFFFF, LO=0xFFFFFFF1, busy=0.
- Unsigned multiply: multu a=0xFFFFFFFF, b=2 gives HI=0x00000001, LO=0xFFFFFFFE after 5 cycles.
- Signed divide: div a=0xFFFFFFF9 (-7), b=2. After 10 cycles LO=0xFFFFFFFD, HI=0xFFFFFFFF. div a=0x80000000, b=0xFFFFFFFF gives LO=0x80000000, HI=0.
- Divide by zero: divu a=7, b=0 gives LO=0xFFFFFFFF, HI=7.
- Ignored inputs while busy:
  - start a divu mid-run, pulse mthi with wdata=0x1234 mid-run → the original result commits at the original edge; HI is not 0x1234.
  - a subsequent idle mthi with wdata=0xABCD → HI=0xABCD.
- Reset and flush mid-run:
  - deassert rst_n mid-div → busy, hi and lo go to 0 immediately; after release, an idle mtlo with wdata=5 → LO=5.
  - with MULDIV_FLUSH_EN defined: flush at cycle 3 of mult → busy=0 next edge, HI/LO unchanged.

Source files
------------

// File: rtl/muldiv_seq.sv
// Multi-cycle multiply/divide unit with HI/LO result registers for the EX stage.
// Optional MULDIV_FLUSH_EN adds a flush input that aborts an in-flight operation.
module muldiv_seq #(
    parameter int unsigned WIDTH      = 32,
    parameter int unsigned MUL_CYCLES = 5,
    parameter int unsigned DIV_CYCLES = 10
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
`ifdef MULDIV_FLUSH_EN
    input  logic             flush,
`endif
    input  logic [1:0]       op,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             mthi,
    input  logic             mtlo,
    input  logic [WIDTH-1:0] wdata,
    output logic             busy,
    output logic [WIDTH-1:0] hi,
    output logic [WIDTH-1:0] lo
);

    localparam int unsigned W2    = 2 * WIDTH;
    localparam int unsigned MAX_C = (MUL_CYCLES > DIV_CYCLES) ? MUL_CYCLES : DIV_CYCLES;
    localparam int unsigned CNT_W = $clog2(MAX_C + 1);

    typedef enum logic {
        S_IDLE = 1'b0,
        S_RUN  = 1'b1
    } state_t;

    state_t             r_state;
    state_t             w_state_nxt;
    logic [CNT_W-1:0]   r_cnt;
    logic [1:0]         r_op;
    logic [WIDTH-1:0]   r_a;
    logic [WIDTH-1:0]   r_b;
    logic [WIDTH-1:0]   r_hi;
    logic [WIDTH-1:0]   r_lo;

    logic               w_flush;
    logic               w_last;
    logic               w_load;
    logic               w_commit;
    logic               w_wr_hi;
    logic               w_wr_lo;

    logic [W2-1:0]      w_prod;
    logic               w_a_neg;
    logic               w_b_neg;
    logic [WIDTH-1:0]   w_a_mag;
    logic [WIDTH-1:0]   w_b_mag;
    logic [WIDTH-1:0]   w_q_mag;
    logic [WIDTH-1:0]   w_r_mag;
    logic [WIDTH-1:0]   w_res_hi;
    logic [WIDTH-1:0]   w_res_lo;

`ifdef MULDIV_FLUSH_EN
    assign w_flush = flush;
`else
    assign w_flush = 1'b0;
`endif

    assign w_last = (r_cnt == CNT_W'(1));

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            S_IDLE:  if (start && !w_flush) w_state_nxt = S_RUN;
            S_RUN:   if (w_flush || w_last) w_state_nxt = S_IDLE;
            default: w_state_nxt = S_IDLE;
        endcase
    end

    // Start has priority over a same-cycle MTHI/MTLO; flush beats the commit.
    always_comb begin
        w_load   = 1'b0;
        w_commit = 1'b0;
        w_wr_hi  = 1'b0;
        w_wr_lo  = 1'b0;
        case (r_state)
            S_IDLE: begin
                if (start) begin
                    w_load = !w_flush;
                end else begin
                    w_wr_hi = mthi;
                    w_wr_lo = mtlo;
                end
            end
            S_RUN:   w_commit = w_last && !w_flush;
            default: ;
        endcase
    end

    // Signed divide works on magnitudes; the quotient sign is the XOR, remainder follows the dividend.
    always_comb begin
        if (r_op[0]) begin
            w_prod = W2'(r_a) * W2'(r_b);
        end else begin
            w_prod = W2'($signed(r_a)) * W2'($signed(r_b));
        end
        w_a_neg = !r_op[0] && r_a[WIDTH-1];
        w_b_neg = !r_op[0] && r_b[WIDTH-1];
        w_a_mag = w_a_neg ? (-r_a) : r_a;
        w_b_mag = w_b_neg ? (-r_b) : r_b;
        w_q_mag = (w_b_mag == '0) ? '0 : (w_a_mag / w_b_mag);
        w_r_mag = (w_b_mag == '0) ? '0 : (w_a_mag % w_b_mag);
        if (!r_op[1]) begin
            w_res_hi = w_prod[W2-1:WIDTH];
            w_res_lo = w_prod[WIDTH-1:0];
        end else if (r_b == '0) begin
            w_res_hi = r_a;
            w_res_lo = '1;
        end else begin
            w_res_hi = w_a_neg ? (-w_r_mag) : w_r_mag;
            w_res_lo = (w_a_neg ^ w_b_neg) ? (-w_q_mag) : w_q_mag;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_cnt <= '0;
            r_op  <= '0;
            r_a   <= '0;
            r_b   <= '0;
            r_hi  <= '0;
            r_lo  <= '0;
        end else begin
            if (w_load) begin
                r_op  <= op;
                r_a   <= a;
                r_b   <= b;
                r_cnt <= op[1] ? CNT_W'(DIV_CYCLES) : CNT_W'(MUL_CYCLES);
            end else if (r_state == S_RUN) begin
                r_cnt <= r_cnt - CNT_W'(1);
            end
            if (w_commit) begin
                r_hi <= w_res_hi;
                r_lo <= w_res_lo;
            end else begin
                if (w_wr_hi) r_hi <= wdata;
                if (w_wr_lo) r_lo <= wdata;
            end
        end
    end

    assign busy = (r_state == S_RUN);
    assign hi   = r_hi;
    assign lo   = r_lo;

endmodule

// File: tb/tb_muldiv_seq.sv
// Scoreboard bench for muldiv_seq: stimulus queues expected HI/LO and busy length,
// a monitor pops and compares each time busy falls.
module tb_muldiv_seq;

    localparam int unsigned W = 32;

    typedef struct {
        logic [W-1:0] hi;
        logic [W-1:0] lo;
        int           cycles;
    } exp_t;

    logic         clk;
    logic         rst_n;
    logic         start;
    logic [1:0]   op;
    logic [W-1:0] a;
    logic [W-1:0] b;
    logic         mthi;
    logic         mtlo;
    logic [W-1:0] wdata;
    logic         busy;
    logic [W-1:0] hi;
    logic [W-1:0] lo;
`ifdef MULDIV_FLUSH_EN
    logic         flush;
`endif

    exp_t sb[$];
    int   n_pass   = 0;
    int   n_total  = 0;
    bit   abort_ok = 1'b0;

    muldiv_seq #(.WIDTH(W), .MUL_CYCLES(5), .DIV_CYCLES(10)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .start (start),
`ifdef MULDIV_FLUSH_EN
        .flush (flush),
`endif
        .op    (op),
        .a     (a),
        .b     (b),
        .mthi  (mthi),
        .mtlo  (mtlo),
        .wdata (wdata),
        .busy  (busy),
        .hi    (hi),
        .lo    (lo)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string name, input logic [W-1:0] act, input logic [W-1:0] exp);
        n_total++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %h expected %h", name, act, exp);
    endtask

    // Monitor: count busy cycles, compare on the falling edge of busy.
    initial begin
        bit   prev_busy = 1'b0;
        int   busy_cycles = 0;
        exp_t e;
        forever begin
            @(negedge clk);
            if (!rst_n) begin
                prev_busy   = 1'b0;
                busy_cycles = 0;
            end else begin
                if (busy) busy_cycles++;
                if (prev_busy && !busy) begin
                    if (sb.size() == 0) begin
                        if (!abort_ok) begin
                            n_total++;
                            $display("FAIL unexpected_done: got busy drop with empty scoreboard, expected none");
                        end
                    end else begin
                        e = sb.pop_front();
                        check("res_hi", hi, e.hi);
                        check("res_lo", lo, e.lo);
                        check("busy_len", W'(busy_cycles), W'(e.cycles));
                    end
                    busy_cycles = 0;
                end
                prev_busy = busy;
            end
        end
    end

    task automatic wait_idle();
        bit done = 1'b0;
        for (int i = 0; i < 40; i++) begin
            @(negedge clk);
            if (!busy) begin
                done = 1'b1;
                break;
            end
        end
        if (!done) begin
            n_total++;
            $display("FAIL idle_timeout: got busy=1 after 40 cycles, expected 0");
        end
    endtask

    task automatic issue(input logic [1:0] o, input logic [W-1:0] aa, input logic [W-1:0] bb,
                         input logic [W-1:0] eh, input logic [W-1:0] el);
        exp_t e;
        wait_idle();
        e.hi = eh;
        e.lo = el;
        e.cycles = o[1] ? 10 : 5;
        sb.push_back(e);
        start = 1'b1; op = o; a = aa; b = bb;
        @(posedge clk); #1;
        start = 1'b0;
    endtask

    initial begin
        rst_n = 1'b0; start = 1'b0; op = '0; a = '0; b = '0;
        mthi = 1'b0; mtlo = 1'b0; wdata = '0;
`ifdef MULDIV_FLUSH_EN
        flush = 1'b0;
`endif
        repeat (2) @(posedge clk);
        #1;
        check("rst_busy", W'(busy), '0);
        check("rst_hi", hi, '0);
        check("rst_lo", lo, '0);
        rst_n = 1'b1;

        issue(2'b00, 32'hFFFF_FFFD, 32'd5, 32'hFFFF_FFFF, 32'hFFFF_FFF1);
        issue(2'b01, 32'hFFFF_FFFF, 32'd2, 32'h0000_0001, 32'hFFFF_FFFE);
        issue(2'b10, 32'hFFFF_FFF9, 32'd2, 32'hFFFF_FFFF, 32'hFFFF_FFFD);
        issue(2'b10, 32'h8000_0000, 32'hFFFF_FFFF, 32'h0000_0000, 32'h8000_0000);
        issue(2'b10, 32'd7, 32'hFFFF_FFFE, 32'h0000_0001, 32'hFFFF_FFFD);
        issue(2'b11, 32'd7, 32'd0, 32'd7, 32'hFFFF_FFFF);

        // Start and MTHI while busy must be ignored; HI shows the old value mid-run.
        issue(2'b11, 32'd100, 32'd7, 32'd2, 32'd14);
        repeat (3) @(negedge clk);
        check("midrun_hi", hi, 32'd7);
        start = 1'b1; op = 2'b11; a = 32'd9; b = 32'd3; mthi = 1'b1; wdata = 32'h1234;
        @(posedge clk); #1;
        start = 1'b0; mthi = 1'b0;

        wait_idle();
        mthi = 1'b1; wdata = 32'hABCD;
        @(posedge clk); #1;
        mthi = 1'b0;
        @(negedge clk);
        check("mthi_hi", hi, 32'hABCD);
        check("mthi_lo", lo, 32'd14);

        // Start in the same idle cycle as MTHI drops the write.
        wait_idle();
        begin
            exp_t e;
            e.hi = 32'd0; e.lo = 32'd42; e.cycles = 5;
            sb.push_back(e);
        end
        start = 1'b1; op = 2'b00; a = 32'd6; b = 32'd7; mthi = 1'b1; wdata = 32'h5555;
        @(posedge clk); #1;
        start = 1'b0; mthi = 1'b0;

        // Asynchronous reset mid-divide.
        wait_idle();
        start = 1'b1; op = 2'b10; a = 32'd100; b = 32'd3;
        @(posedge clk); #1;
        start = 1'b0;
        repeat (4) @(negedge clk);
        check("pre_rst_busy", W'(busy), W'(1));
        #2 rst_n = 1'b0;
        #1;
        check("async_busy", W'(busy), '0);
        check("async_hi", hi, '0);
        check("async_lo", lo, '0);
        @(negedge clk);
        @(posedge clk); #1;
        rst_n = 1'b1;
        mtlo = 1'b1; wdata = 32'd5;
        @(posedge clk); #1;
        mtlo = 1'b0;
        @(negedge clk);
        check("mtlo_lo", lo, 32'd5);
        check("mtlo_hi", hi, 32'd0);

`ifdef MULDIV_FLUSH_EN
        wait_idle();
        abort_ok = 1'b1;
        start = 1'b1; op = 2'b00; a = 32'd3; b = 32'd3;
        @(posedge clk); #1;
        start = 1'b0;
        repeat (2) @(posedge clk);
        #1 flush = 1'b1;
        @(posedge clk); #1;
        flush = 1'b0;
        check("flush_busy", W'(busy), '0);
        check("flush_hi", hi, 32'd0);
        check("flush_lo", lo, 32'd5);
        start = 1'b1; flush = 1'b1;
        @(posedge clk); #1;
        start = 1'b0; flush = 1'b0;
        check("flush_start_busy", W'(busy), '0);
        repeat (8) @(negedge clk);
        check("flush_start_lo", lo, 32'd5);
        abort_ok = 1'b0;
`endif

        repeat (3) @(negedge clk);
        check("sb_empty", W'(sb.size()), '0);
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL watchdog: got timeout, expected completion");
        $fatal(1, "watchdog");
    end

endmodule
